// File: rtl/hdmi_timing_gen.sv
// Raster timing for the HDMI output path: free-running line/frame counters,
// a fetch window one clock ahead of de, and pixel-aligned sync/de/coordinates.
module hdmi_timing_gen #(
  parameter int   H_SYNC  = 136,
  parameter int   H_BACK  = 160,
  parameter int   H_DISP  = 1024,
  parameter int   H_FRONT = 24,
  parameter int   H_TOTAL = 1344,
  parameter int   V_SYNC  = 6,
  parameter int   V_BACK  = 29,
  parameter int   V_DISP  = 768,
  parameter int   V_FRONT = 3,
  parameter int   V_TOTAL = 806,
  parameter logic H_POL   = 1'b0,
  parameter logic V_POL   = 1'b0
) (
  input  logic        hdmi_clk,
  input  logic        sys_rst_n,
  output logic [11:0] hcnt,
  output logic [11:0] vcnt,
  output logic        all_photo_en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic        line_end
);

  typedef enum logic [1:0] {SYNC, BACK, DISP, FRONT} phase_t;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_SYNC_END = 12'(H_SYNC - 1);
  localparam logic [11:0] H_BACK_END = 12'(H_SYNC + H_BACK - 1);
  localparam logic [11:0] H_DISP_END = 12'(H_TOTAL - H_FRONT - 1);
  localparam logic [11:0] H_FETCH_LO = 12'(H_SYNC + H_BACK - 1);
  localparam logic [11:0] H_FETCH_HI = 12'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_SYNC_END = 12'(V_SYNC - 1);
  localparam logic [11:0] V_BACK_END = 12'(V_SYNC + V_BACK - 1);
  localparam logic [11:0] V_DISP_END = 12'(V_TOTAL - V_FRONT - 1);
  localparam logic [11:0] V_ACT      = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_ACT_END  = 12'(V_SYNC + V_BACK + V_DISP);

  phase_t h_st;
  phase_t v_st;
  logic   line_last;

  assign line_last = (hcnt == H_LAST);

  // Fetch window leads de by one clock so the SDRAM read path has a cycle of slack.
  assign all_photo_en = (hcnt >= H_FETCH_LO) && (hcnt < H_FETCH_HI) &&
                        (vcnt >= V_ACT) && (vcnt < V_ACT_END);

  always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= line_last ? 12'd0 : hcnt + 12'd1;
      if (line_last)
        vcnt <= (vcnt == V_LAST) ? 12'd0 : vcnt + 12'd1;
    end
  end

  // Phase FSMs step on the same edge the counter crosses a boundary, so state always matches range.
  always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_st <= SYNC;
    end else begin
      case (h_st)
        SYNC:    if (hcnt == H_SYNC_END) h_st <= BACK;
        BACK:    if (hcnt == H_BACK_END) h_st <= DISP;
        DISP:    if (hcnt == H_DISP_END) h_st <= FRONT;
        FRONT:   if (line_last)          h_st <= SYNC;
        default: h_st <= SYNC;
      endcase
    end
  end

  always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v_st <= SYNC;
    end else if (line_last) begin
      case (v_st)
        SYNC:    if (vcnt == V_SYNC_END) v_st <= BACK;
        BACK:    if (vcnt == V_BACK_END) v_st <= DISP;
        DISP:    if (vcnt == V_DISP_END) v_st <= FRONT;
        FRONT:   if (vcnt == V_LAST)     v_st <= SYNC;
        default: v_st <= SYNC;
      endcase
    end
  end

  // Pixel-side outputs are one clock behind the counters; pix_x uses the fetch-cycle hcnt.
  always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
    end else begin
      hsync       <= (h_st == SYNC) ? H_POL : ~H_POL;
      vsync       <= (v_st == SYNC) ? V_POL : ~V_POL;
      de          <= all_photo_en;
      pix_x       <= all_photo_en ? 11'(hcnt - H_FETCH_LO) : 11'd0;
      pix_y       <= all_photo_en ? 10'(vcnt - V_ACT) : 10'd0;
      frame_start <= (hcnt == 12'd0) && (vcnt == 12'd0);
      line_end    <= line_last;
    end
  end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Directed bench for hdmi_timing_gen: a default-timing instance for reset, line and
// fetch-window behaviour, and a small-parameter instance checked cycle by cycle.
module tb_hdmi_timing_gen;

  logic hdmi_clk;
  logic rst_b_n;
  logic rst_s_n;

  logic [11:0] hcnt_b, vcnt_b, hcnt_s, vcnt_s;
  logic        ape_b, hsync_b, vsync_b, de_b, fs_b, le_b;
  logic        ape_s, hsync_s, vsync_s, de_s, fs_s, le_s;
  logic [10:0] pix_x_b, pix_x_s;
  logic [9:0]  pix_y_b, pix_y_s;

  int total = 0;
  int bad   = 0;

  hdmi_timing_gen dut_b (
    .hdmi_clk(hdmi_clk), .sys_rst_n(rst_b_n), .hcnt(hcnt_b), .vcnt(vcnt_b),
    .all_photo_en(ape_b), .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
    .pix_x(pix_x_b), .pix_y(pix_y_b), .frame_start(fs_b), .line_end(le_b)
  );

  hdmi_timing_gen #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2), .H_TOTAL(10),
    .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1), .V_TOTAL(6)
  ) dut_s (
    .hdmi_clk(hdmi_clk), .sys_rst_n(rst_s_n), .hcnt(hcnt_s), .vcnt(vcnt_s),
    .all_photo_en(ape_s), .hsync(hsync_s), .vsync(vsync_s), .de(de_s),
    .pix_x(pix_x_s), .pix_y(pix_y_s), .frame_start(fs_s), .line_end(le_s)
  );

  initial begin
    hdmi_clk = 1'b0;
    forever #5 hdmi_clk = ~hdmi_clk;
  end

  task automatic applyStimulus(input logic big_rst_n, input logic small_rst_n);
    rst_b_n = big_rst_n;
    rst_s_n = small_rst_n;
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int phaseOf(input int c, input int s, input int b, input int d);
    if (c < s) return 0;
    if (c < s + b) return 1;
    if (c < s + b + d) return 2;
    return 3;
  endfunction

  function automatic int smallFetch(input int pos);
    int hq = pos % 10;
    int vq = (pos / 10) % 6;
    return (hq >= 3 && hq <= 6 && vq >= 2 && vq <= 4) ? 1 : 0;
  endfunction

  task automatic checkBigReset(input string tag);
    checkOutput({tag, "_hcnt"}, int'(hcnt_b), 0);
    checkOutput({tag, "_vcnt"}, int'(vcnt_b), 0);
    checkOutput({tag, "_hsync"}, int'(hsync_b), 1);
    checkOutput({tag, "_vsync"}, int'(vsync_b), 1);
    checkOutput({tag, "_de"}, int'(de_b), 0);
    checkOutput({tag, "_pix_x"}, int'(pix_x_b), 0);
    checkOutput({tag, "_pix_y"}, int'(pix_y_b), 0);
    checkOutput({tag, "_fs"}, int'(fs_b), 0);
    checkOutput({tag, "_le"}, int'(le_b), 0);
  endtask

  task automatic checkSmallReset(input string tag);
    checkOutput({tag, "_hcnt"}, int'(hcnt_s), 0);
    checkOutput({tag, "_vcnt"}, int'(vcnt_s), 0);
    checkOutput({tag, "_hsync"}, int'(hsync_s), 1);
    checkOutput({tag, "_vsync"}, int'(vsync_s), 1);
    checkOutput({tag, "_de"}, int'(de_s), 0);
    checkOutput({tag, "_pix_x"}, int'(pix_x_s), 0);
    checkOutput({tag, "_fs"}, int'(fs_s), 0);
    checkOutput({tag, "_le"}, int'(le_s), 0);
  endtask

  localparam int K_BIG = 36 * 1344 + 300;

  initial begin
    int hs_low = 0, vs_low = 0, le_cnt = 0, fs_cnt = 0;
    int fetch_seen = 0, fetch_k = 0;
    int de_cnt_s = 0, fs_cnt_s = 0;

    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge hdmi_clk);
    checkBigReset("rst");
    checkSmallReset("rst_s");

    // Default timing: reset release, first line, fetch window onset.
    applyStimulus(1'b1, 1'b0);
    for (int k = 1; k <= K_BIG; k++) begin
      @(negedge hdmi_clk);
      if (k == 1) begin
        checkOutput("first_hcnt", int'(hcnt_b), 1);
        checkOutput("first_vcnt", int'(vcnt_b), 0);
        checkOutput("first_fs", int'(fs_b), 1);
        checkOutput("first_hsync", int'(hsync_b), 0);
        checkOutput("first_vsync", int'(vsync_b), 0);
      end
      if (k <= 1344 && !hsync_b) hs_low++;
      if (!vsync_b) vs_low++;
      if (le_b) le_cnt++;
      if (fs_b) fs_cnt++;
      if (k == 1343) begin
        checkOutput("wrap_pre_hcnt", int'(hcnt_b), 1343);
        checkOutput("wrap_pre_vcnt", int'(vcnt_b), 0);
        checkOutput("wrap_pre_le", int'(le_b), 0);
      end
      if (k == 1344) begin
        checkOutput("wrap_hcnt", int'(hcnt_b), 0);
        checkOutput("wrap_vcnt", int'(vcnt_b), 1);
        checkOutput("wrap_le", int'(le_b), 1);
      end
      if (fetch_seen == 0 && ape_b) begin
        fetch_seen = 1;
        fetch_k = k;
        checkOutput("fetch_hcnt", int'(hcnt_b), 295);
        checkOutput("fetch_vcnt", int'(vcnt_b), 35);
        checkOutput("fetch_de_pre", int'(de_b), 0);
      end
      if (fetch_seen == 1 && k == fetch_k + 1) begin
        checkOutput("de_first", int'(de_b), 1);
        checkOutput("de_first_px", int'(pix_x_b), 0);
        checkOutput("de_first_py", int'(pix_y_b), 0);
      end
      if (fetch_seen == 1 && k == fetch_k + 1024) begin
        checkOutput("de_last", int'(de_b), 1);
        checkOutput("de_last_px", int'(pix_x_b), 1023);
      end
      if (fetch_seen == 1 && k == fetch_k + 1025) begin
        checkOutput("de_after", int'(de_b), 0);
        checkOutput("de_after_px", int'(pix_x_b), 0);
      end
    end
    checkOutput("hsync_low_clks", hs_low, 136);
    checkOutput("vsync_low_clks", vs_low, 6 * 1344);
    checkOutput("line_end_count", le_cnt, 36);
    checkOutput("frame_start_count", fs_cnt, 1);
    checkOutput("fetch_found", fetch_seen, 1);
    checkOutput("mid_vcnt", int'(vcnt_b), 36);
    checkOutput("mid_hcnt", int'(hcnt_b), 300);
    checkOutput("mid_de", int'(de_b), 1);
    checkOutput("mid_px", int'(pix_x_b), 4);
    checkOutput("mid_py", int'(pix_y_b), 1);

    // Mid-frame asynchronous reset, sampled well before the next rising edge.
    applyStimulus(1'b0, 1'b0);
    #1;
    checkBigReset("async");
    repeat (3) @(negedge hdmi_clk);
    checkBigReset("held");
    applyStimulus(1'b1, 1'b0);
    @(negedge hdmi_clk);
    checkOutput("restart_hcnt", int'(hcnt_b), 1);
    checkOutput("restart_vcnt", int'(vcnt_b), 0);
    checkOutput("restart_fs", int'(fs_b), 1);
    checkOutput("restart_hsync", int'(hsync_b), 0);

    // Small timing: every output and both phase FSMs against a position-based model.
    $display("[TB] small-parameter instance");
    applyStimulus(1'b0, 1'b1);
    for (int k = 1; k <= 154; k++) begin
      int hp, vp, q, hq, vq, f;
      @(negedge hdmi_clk);
      hp = k % 10;
      vp = (k / 10) % 6;
      q  = k - 1;
      hq = q % 10;
      vq = (q / 10) % 6;
      f  = smallFetch(q);
      checkOutput("s_hcnt", int'(hcnt_s), hp);
      checkOutput("s_vcnt", int'(vcnt_s), vp);
      checkOutput("s_h_st", int'(dut_s.h_st), phaseOf(hp, 2, 2, 4));
      checkOutput("s_v_st", int'(dut_s.v_st), phaseOf(vp, 1, 1, 3));
      checkOutput("s_ape", int'(ape_s), smallFetch(k));
      checkOutput("s_de", int'(de_s), f);
      checkOutput("s_px", int'(pix_x_s), (f == 1) ? hq - 3 : 0);
      checkOutput("s_py", int'(pix_y_s), (f == 1) ? vq - 2 : 0);
      checkOutput("s_hsync", int'(hsync_s), (hq < 2) ? 0 : 1);
      checkOutput("s_vsync", int'(vsync_s), (vq < 1) ? 0 : 1);
      checkOutput("s_fs", int'(fs_s), (q % 60 == 0) ? 1 : 0);
      checkOutput("s_le", int'(le_s), (hq == 9) ? 1 : 0);
      if (k <= 120 && de_s) de_cnt_s++;
      if (k <= 120 && fs_s) fs_cnt_s++;
    end
    checkOutput("s_de_two_frames", de_cnt_s, 24);
    checkOutput("s_fs_two_frames", fs_cnt_s, 2);

    applyStimulus(1'b0, 1'b0);
    #1;
    checkSmallReset("s_async");
    repeat (3) @(negedge hdmi_clk);
    applyStimulus(1'b0, 1'b1);
    @(negedge hdmi_clk);
    checkOutput("s_restart_hcnt", int'(hcnt_s), 1);
    checkOutput("s_restart_fs", int'(fs_s), 1);
    checkOutput("s_restart_h_st", int'(dut_s.h_st), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
